execute_stage: RTL and testbench

Execute stage of the 5-stage RV32IM pipeline, between decode and the memory stage. Computes the ALU/M-extension result from decoded operands and registers it into the EX/MEM boundary. Outputs are alu_result, store data, rd and control flags. Most ops complete in one cycle. DIV/DIVU/REM/REMU run on an iterative 32-step divider, and the block holds the upstream stages with `stall` while it runs.

---
 rtl/rv_pkg.sv | 39 +++
 rtl/div_unit.sv | 116 +++++++++++
 rtl/execute_stage.sv | 126 ++++++++++++
 tb/tb_execute_stage.sv | 268 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/rv_pkg.sv
// Shared encodings for the RV32IM execute stage: ALU operation codes,
// divider FSM states and the divide-op classifier.
package rv_pkg;

  localparam int DIV_STEPS = 32;

  typedef enum logic [4:0] {
    ALU_ADD    = 5'd0,
    ALU_SUB    = 5'd1,
    ALU_SLL    = 5'd2,
    ALU_SLT    = 5'd3,
    ALU_SLTU   = 5'd4,
    ALU_XOR    = 5'd5,
    ALU_SRL    = 5'd6,
    ALU_SRA    = 5'd7,
    ALU_OR     = 5'd8,
    ALU_AND    = 5'd9,
    ALU_PASSB  = 5'd10,
    ALU_MUL    = 5'd11,
    ALU_MULH   = 5'd12,
    ALU_MULHSU = 5'd13,
    ALU_MULHU  = 5'd14,
    ALU_DIV    = 5'd15,
    ALU_DIVU   = 5'd16,
    ALU_REM    = 5'd17,
    ALU_REMU   = 5'd18
  } alu_op_t;

  typedef enum logic [1:0] {
    DIV_IDLE = 2'd0,
    DIV_RUN  = 2'd1,
    DIV_DONE = 2'd2
  } div_state_t;

  function automatic logic is_div(input logic [4:0] op);
    return (op == ALU_DIV) || (op == ALU_DIVU) || (op == ALU_REM) || (op == ALU_REMU);
  endfunction

endpackage

// File: rtl/div_unit.sv
// Iterative 32-step restoring divider with sign fix-up. Divide-by-zero and
// signed overflow skip the iteration and go straight to DONE.
module div_unit
  import rv_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic        kill,
  input  logic        signed_op,
  input  logic        want_rem,
  input  logic [31:0] dividend,
  input  logic [31:0] divisor,
  output logic        busy,
  output logic        done,
  output logic [31:0] result,
  output div_state_t  state
);

  div_state_t  state_q, state_d;
  logic [4:0]  count_q;
  logic [31:0] rem_q, quo_q, dvs_q, result_q;
  logic        neg_q_q, neg_r_q, rem_sel_q;

  logic        div_zero, overflow, special;
  logic        a_neg, b_neg;
  logic [31:0] a_mag, b_mag, special_result;
  logic [32:0] shifted, trial;
  logic        ge;
  logic [31:0] rem_next, quo_next, q_fix, r_fix;

  assign div_zero = (divisor == 32'd0);
  assign overflow = signed_op && (dividend == 32'h8000_0000) && (divisor == 32'hFFFF_FFFF);
  assign special  = div_zero || overflow;
  assign a_neg    = signed_op & dividend[31];
  assign b_neg    = signed_op & divisor[31];
  assign a_mag    = a_neg ? (32'd0 - dividend) : dividend;
  assign b_mag    = b_neg ? (32'd0 - divisor) : divisor;

  assign special_result = div_zero ? (want_rem ? dividend : 32'hFFFF_FFFF)
                                   : (want_rem ? 32'd0 : 32'h8000_0000);

  // Partial remainder stays below the divisor, so trial[32] is a clean borrow.
  assign shifted  = {rem_q, quo_q[31]};
  assign trial    = shifted - {1'b0, dvs_q};
  assign ge       = ~trial[32];
  assign rem_next = ge ? trial[31:0] : shifted[31:0];
  assign quo_next = {quo_q[30:0], ge};
  assign q_fix    = neg_q_q ? (32'd0 - quo_next) : quo_next;
  assign r_fix    = neg_r_q ? (32'd0 - rem_next) : rem_next;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= DIV_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    busy    = 1'b0;
    if (kill) begin
      state_d = DIV_IDLE;
    end else begin
      case (state_q)
        DIV_IDLE: begin
          if (start) begin
            busy    = 1'b1;
            state_d = special ? DIV_DONE : DIV_RUN;
          end
        end
        DIV_RUN: begin
          busy = 1'b1;
          if (count_q == 5'(DIV_STEPS - 1)) state_d = DIV_DONE;
        end
        DIV_DONE: state_d = DIV_IDLE;
        default:  state_d = DIV_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q   <= '0;
      rem_q     <= '0;
      quo_q     <= '0;
      dvs_q     <= '0;
      result_q  <= '0;
      neg_q_q   <= 1'b0;
      neg_r_q   <= 1'b0;
      rem_sel_q <= 1'b0;
    end else if (kill) begin
      count_q <= '0;
    end else if (state_q == DIV_IDLE && start) begin
      if (special) begin
        result_q <= special_result;
      end else begin
        count_q   <= '0;
        rem_q     <= '0;
        quo_q     <= a_mag;
        dvs_q     <= b_mag;
        neg_q_q   <= a_neg ^ b_neg;
        neg_r_q   <= a_neg;
        rem_sel_q <= want_rem;
      end
    end else if (state_q == DIV_RUN) begin
      rem_q   <= rem_next;
      quo_q   <= quo_next;
      count_q <= count_q + 5'd1;
      if (count_q == 5'(DIV_STEPS - 1)) result_q <= rem_sel_q ? r_fix : q_fix;
    end
  end

  assign done   = (state_q == DIV_DONE);
  assign result = result_q;
  assign state  = state_q;

endmodule

// File: rtl/execute_stage.sv
// RV32IM execute stage: single-cycle ALU/multiplier plus iterative divider,
// registered into the EX/MEM boundary.
module execute_stage
  import rv_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            valid_in,
  input  logic            flush,
  input  logic [4:0]      alu_op,
  input  logic [XLEN-1:0] rs1_data,
  input  logic [XLEN-1:0] rs2_data,
  input  logic [XLEN-1:0] imm,
  input  logic            use_imm,
  input  logic [4:0]      rd,
  input  logic            reg_write,
  input  logic            mem_read,
  input  logic            mem_write,
  output logic            stall,
  output logic            valid_out,
  output logic [XLEN-1:0] alu_result,
  output logic [XLEN-1:0] rs2_data_out,
  output logic [4:0]      rd_out,
  output logic            reg_write_out,
  output logic            mem_read_out,
  output logic            mem_write_out,
  output div_state_t      div_state
);

  // Handshake: stall is combinational and means "hold every input stable";
  // any rising edge with stall=0 and flush=0 accepts the presented instruction.

  logic [31:0] op_b;
  logic [4:0]  shamt;
  logic [63:0] mul_a, mul_b, mul_p;
  logic        mul_a_signed, mul_b_signed;
  logic [31:0] alu_res, result;
  logic        div_start, div_busy, div_done;
  logic [31:0] div_result;
  logic        accept;

  assign op_b  = use_imm ? imm : rs2_data;
  assign shamt = op_b[4:0];

  // One 64-bit multiplier serves all MUL variants; sign extension picks the flavour.
  assign mul_a_signed = (alu_op == ALU_MULH) || (alu_op == ALU_MULHSU);
  assign mul_b_signed = (alu_op == ALU_MULH);
  assign mul_a = {{32{mul_a_signed & rs1_data[31]}}, rs1_data};
  assign mul_b = {{32{mul_b_signed & op_b[31]}}, op_b};
  assign mul_p = mul_a * mul_b;

  always_comb begin
    alu_res = '0;
    case (alu_op)
      ALU_ADD:    alu_res = rs1_data + op_b;
      ALU_SUB:    alu_res = rs1_data - op_b;
      ALU_SLL:    alu_res = rs1_data << shamt;
      ALU_SLT:    alu_res = {31'd0, $signed(rs1_data) < $signed(op_b)};
      ALU_SLTU:   alu_res = {31'd0, rs1_data < op_b};
      ALU_XOR:    alu_res = rs1_data ^ op_b;
      ALU_SRL:    alu_res = rs1_data >> shamt;
      ALU_SRA:    alu_res = $unsigned($signed(rs1_data) >>> shamt);
      ALU_OR:     alu_res = rs1_data | op_b;
      ALU_AND:    alu_res = rs1_data & op_b;
      ALU_PASSB:  alu_res = op_b;
      ALU_MUL:    alu_res = mul_p[31:0];
      ALU_MULH,
      ALU_MULHSU,
      ALU_MULHU:  alu_res = mul_p[63:32];
      default:    alu_res = '0;
    endcase
  end

  assign div_start = valid_in && is_div(alu_op);

  div_unit u_div (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (div_start),
    .kill      (flush),
    .signed_op ((alu_op == ALU_DIV) || (alu_op == ALU_REM)),
    .want_rem  ((alu_op == ALU_REM) || (alu_op == ALU_REMU)),
    .dividend  (rs1_data),
    .divisor   (op_b),
    .busy      (div_busy),
    .done      (div_done),
    .result    (div_result),
    .state     (div_state)
  );

  assign stall  = div_busy;
  assign result = is_div(alu_op) ? (div_done ? div_result : 32'd0) : alu_res;
  assign accept = valid_in && !stall && !flush;

  // Bubbles clear the whole EX/MEM register, not just the control bits.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_out     <= 1'b0;
      alu_result    <= '0;
      rs2_data_out  <= '0;
      rd_out        <= '0;
      reg_write_out <= 1'b0;
      mem_read_out  <= 1'b0;
      mem_write_out <= 1'b0;
    end else if (accept) begin
      valid_out     <= 1'b1;
      alu_result    <= result;
      rs2_data_out  <= rs2_data;
      rd_out        <= rd;
      reg_write_out <= reg_write;
      mem_read_out  <= mem_read;
      mem_write_out <= mem_write;
    end else begin
      valid_out     <= 1'b0;
      alu_result    <= '0;
      rs2_data_out  <= '0;
      rd_out        <= '0;
      reg_write_out <= 1'b0;
      mem_read_out  <= 1'b0;
      mem_write_out <= 1'b0;
    end
  end

endmodule

// File: tb/tb_execute_stage.sv
// Self-checking bench for execute_stage: directed vector table, flush and
// reset sequences, and randomized ops against an arithmetic reference model.
module tb_execute_stage;
  import rv_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        valid_in, flush;
  logic [4:0]  alu_op;
  logic [31:0] rs1_data, rs2_data, imm;
  logic        use_imm;
  logic [4:0]  rd;
  logic        reg_write, mem_read, mem_write;
  logic        stall, valid_out;
  logic [31:0] alu_result, rs2_data_out;
  logic [4:0]  rd_out;
  logic        reg_write_out, mem_read_out, mem_write_out;
  div_state_t  div_state;

  int checks   = 0;
  int failures = 0;

  execute_stage #(.XLEN(32)) dut (
    .clk(clk), .rst_n(rst_n), .valid_in(valid_in), .flush(flush),
    .alu_op(alu_op), .rs1_data(rs1_data), .rs2_data(rs2_data), .imm(imm),
    .use_imm(use_imm), .rd(rd), .reg_write(reg_write), .mem_read(mem_read),
    .mem_write(mem_write), .stall(stall), .valid_out(valid_out),
    .alu_result(alu_result), .rs2_data_out(rs2_data_out), .rd_out(rd_out),
    .reg_write_out(reg_write_out), .mem_read_out(mem_read_out),
    .mem_write_out(mem_write_out), .div_state(div_state)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, checks=%0d", checks);
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // Reference model, written straight from the instruction semantics.
  function automatic logic [31:0] ref_alu(input logic [4:0] op, input logic [31:0] a,
                                          input logic [31:0] b);
    longint          sa  = longint'($signed(a));
    longint          sb  = longint'($signed(b));
    longint          sbu = longint'({32'd0, b});
    longint unsigned ua  = {32'd0, a};
    longint unsigned ub  = {32'd0, b};
    logic [63:0]     t;
    logic [4:0]      sh  = b[4:0];
    logic            ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
    case (op)
      5'd0:  return a + b;
      5'd1:  return a - b;
      5'd2:  return a << sh;
      5'd3:  return (sa < sb) ? 32'd1 : 32'd0;
      5'd4:  return (a < b) ? 32'd1 : 32'd0;
      5'd5:  return a ^ b;
      5'd6:  return a >> sh;
      5'd7:  begin t = sa >>> sh; return t[31:0]; end
      5'd8:  return a | b;
      5'd9:  return a & b;
      5'd10: return b;
      5'd11: begin t = ua * ub;  return t[31:0]; end
      5'd12: begin t = sa * sb;  return t[63:32]; end
      5'd13: begin t = sa * sbu; return t[63:32]; end
      5'd14: begin t = ua * ub;  return t[63:32]; end
      5'd15: begin
        if (b == 0) return 32'hFFFF_FFFF;
        if (ovf)    return 32'h8000_0000;
        t = sa / sb; return t[31:0];
      end
      5'd16: begin
        if (b == 0) return 32'hFFFF_FFFF;
        t = ua / ub; return t[31:0];
      end
      5'd17: begin
        if (b == 0) return a;
        if (ovf)    return 32'd0;
        t = sa % sb; return t[31:0];
      end
      5'd18: begin
        if (b == 0) return a;
        t = ua % ub; return t[31:0];
      end
      default: return 32'd0;
    endcase
  endfunction

  function automatic int ref_stalls(input logic [4:0] op, input logic [31:0] a,
                                    input logic [31:0] b);
    if (op < 5'd15 || op > 5'd18) return 0;
    if (b == 0) return 1;
    if ((op == 5'd15 || op == 5'd17) && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 1;
    return 33;
  endfunction

  // Present one instruction (called #1 after a rising edge), follow it through
  // any stall, and check the EX/MEM outputs after its accept edge.
  task automatic exec(input logic [4:0] op, input logic [31:0] a, input logic [31:0] r2,
                      input logic [31:0] im, input logic ui, input logic [31:0] exp,
                      input int exp_st, input string name);
    int         st = 0;
    logic [7:0] ctl;
    valid_in  = 1'b1;
    flush     = 1'b0;
    alu_op    = op;
    rs1_data  = a;
    rs2_data  = r2;
    imm       = im;
    use_imm   = ui;
    rd        = 5'($urandom_range(1, 31));
    reg_write = 1'($urandom_range(0, 1));
    mem_read  = 1'($urandom_range(0, 1));
    mem_write = 1'($urandom_range(0, 1));
    ctl       = {rd, reg_write, mem_read, mem_write};
    #1;
    while (stall === 1'b1 && st < 40) begin
      st++;
      @(posedge clk); #1;
      check({name, "_bubble"},
            {28'd0, valid_out, reg_write_out, mem_read_out, mem_write_out}, 32'd0);
    end
    check({name, "_stall_cycles"}, st, exp_st);
    @(posedge clk); #1;
    check({name, "_valid"}, {31'd0, valid_out}, 32'd1);
    check({name, "_result"}, alu_result, exp);
    check({name, "_store_data"}, rs2_data_out, r2);
    check({name, "_ctl"}, {24'd0, rd_out, reg_write_out, mem_read_out, mem_write_out},
          {24'd0, ctl});
  endtask

  task automatic bubble_cycle(input string name);
    valid_in = 1'b0;
    alu_op   = 5'($urandom_range(0, 18));
    #1;
    check({name, "_stall"}, {31'd0, stall}, 32'd0);
    @(posedge clk); #1;
    check({name, "_out"}, {28'd0, valid_out, reg_write_out, mem_read_out, mem_write_out},
          32'd0);
  endtask

  task automatic check_all_zero(input string name);
    check({name, "_valid"}, {31'd0, valid_out}, 32'd0);
    check({name, "_result"}, alu_result, 32'd0);
    check({name, "_store_data"}, rs2_data_out, 32'd0);
    check({name, "_ctl"}, {24'd0, rd_out, reg_write_out, mem_read_out, mem_write_out}, 32'd0);
    check({name, "_stall"}, {31'd0, stall}, 32'd0);
    check({name, "_state"}, {30'd0, div_state}, {30'd0, DIV_IDLE});
  endtask

  typedef struct {
    logic [4:0]  op;
    logic [31:0] a;
    logic [31:0] r2;
    logic [31:0] im;
    logic        ui;
    logic [31:0] exp;
    int          st;
  } vec_t;

  vec_t tbl[18];

  initial begin
    tbl[0]  = '{ALU_ADD,    32'd5,          32'd7,          32'd0,          1'b0, 32'h0000_000C, 0};
    tbl[1]  = '{ALU_SRA,    32'h8000_0000, 32'h0000_DEAD,  32'd4,          1'b1, 32'hF800_0000, 0};
    tbl[2]  = '{ALU_MULH,   32'h8000_0000, 32'h8000_0000,  32'd0,          1'b0, 32'h4000_0000, 0};
    tbl[3]  = '{ALU_MULHU,  32'hFFFF_FFFF, 32'hFFFF_FFFF,  32'd0,          1'b0, 32'hFFFF_FFFE, 0};
    tbl[4]  = '{ALU_DIVU,   32'd100,        32'd7,          32'd0,          1'b0, 32'd14,        33};
    tbl[5]  = '{ALU_REM,    32'hFFFF_FFF9, 32'd2,          32'd0,          1'b0, 32'hFFFF_FFFF, 33};
    tbl[6]  = '{ALU_DIV,    32'h0000_1234, 32'd0,          32'd0,          1'b0, 32'hFFFF_FFFF, 1};
    tbl[7]  = '{ALU_DIV,    32'h8000_0000, 32'hFFFF_FFFF,  32'd0,          1'b0, 32'h8000_0000, 1};
    tbl[8]  = '{ALU_REM,    32'h8000_0000, 32'hFFFF_FFFF,  32'd0,          1'b0, 32'd0,         1};
    tbl[9]  = '{ALU_REMU,   32'd10,         32'd0,          32'd0,          1'b0, 32'd10,        1};
    tbl[10] = '{ALU_SUB,    32'd3,          32'd5,          32'd0,          1'b0, 32'hFFFF_FFFE, 0};
    tbl[11] = '{ALU_SLT,    32'hFFFF_FFFF, 32'd1,          32'd0,          1'b0, 32'd1,         0};
    tbl[12] = '{ALU_SLTU,   32'hFFFF_FFFF, 32'd1,          32'd0,          1'b0, 32'd0,         0};
    tbl[13] = '{ALU_PASSB,  32'h0000_0055, 32'h0000_0077,  32'h1234_5000,  1'b1, 32'h1234_5000, 0};
    tbl[14] = '{ALU_MULHSU, 32'hFFFF_FFFF, 32'd2,          32'd0,          1'b0, 32'hFFFF_FFFF, 0};
    tbl[15] = '{ALU_DIV,    32'hFFFF_FFF9, 32'd2,          32'd0,          1'b0, 32'hFFFF_FFFD, 33};
    tbl[16] = '{5'd25,      32'd9,          32'd9,          32'd0,          1'b0, 32'd0,         0};
    tbl[17] = '{ALU_SLL,    32'd1,          32'h0000_0021,  32'd0,          1'b0, 32'd2,         0};

    rst_n = 1'b0; valid_in = 1'b0; flush = 1'b0; alu_op = '0;
    rs1_data = '0; rs2_data = '0; imm = '0; use_imm = 1'b0; rd = '0;
    reg_write = 1'b0; mem_read = 1'b0; mem_write = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check_all_zero("reset");
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;

    for (int i = 0; i < 18; i++)
      exec(tbl[i].op, tbl[i].a, tbl[i].r2, tbl[i].im, tbl[i].ui, tbl[i].exp, tbl[i].st,
           $sformatf("vec%0d", i));

    bubble_cycle("bubble");

    // Flush in the 10th RUN cycle of a divide.
    valid_in = 1'b1; alu_op = ALU_DIVU; rs1_data = 32'd100; rs2_data = 32'd7; use_imm = 1'b0;
    #1;
    check("flush_div_stall", {31'd0, stall}, 32'd1);
    repeat (10) @(posedge clk);
    #1;
    check("flush_run_stall", {31'd0, stall}, 32'd1);
    flush = 1'b1;
    #1;
    check("flush_stall_drop", {31'd0, stall}, 32'd0);
    @(posedge clk); #1;
    check("flush_bubble", {31'd0, valid_out}, 32'd0);
    check("flush_state", {30'd0, div_state}, {30'd0, DIV_IDLE});
    exec(ALU_ADD, 32'd1, 32'd1, 32'd0, 1'b0, 32'd2, 0, "post_flush_add");

    // Reset pulse right after a completed op clears the outputs at once.
    valid_in = 1'b0;
    #3 rst_n = 1'b0;
    #1;
    check_all_zero("reset_pulse");
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;

    // Reset in the middle of a division abandons it.
    valid_in = 1'b1; alu_op = ALU_DIVU; rs1_data = 32'd100; rs2_data = 32'd7; use_imm = 1'b0;
    repeat (6) @(posedge clk);
    #3;
    rst_n = 1'b0; valid_in = 1'b0;
    #1;
    check_all_zero("reset_mid_div");
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;
    exec(ALU_DIVU, 32'd9, 32'd3, 32'd0, 1'b0, 32'd3, 33, "post_reset_divu");

    // Randomized ops against the reference model, back-to-back with occasional bubbles.
    for (int n = 0; n < 150; n++) begin
      logic [4:0]  op;
      logic [31:0] a, r2, im, b;
      logic        ui;
      op = 5'($urandom_range(0, 18));
      a  = $urandom;
      r2 = $urandom;
      im = $urandom;
      ui = 1'b0;
      case ($urandom_range(0, 7))
        0: r2 = 32'd0;
        1: r2 = 32'($urandom_range(1, 15));
        2: begin a = 32'h8000_0000; r2 = 32'hFFFF_FFFF; end
        default: ;
      endcase
      if (op < 5'd15) ui = 1'($urandom_range(0, 1));
      b = ui ? im : r2;
      exec(op, a, r2, im, ui, ref_alu(op, a, b), ref_stalls(op, a, b),
           $sformatf("rand%0d_op%0d", n, op));
      if ($urandom_range(0, 5) == 0) bubble_cycle($sformatf("rand%0d_bubble", n));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
